// File: rtl/register4_async_reset.sv
// Resettable word register: loads data on every rising clk edge, or RESET_VALUE
// when the synchronous active-high reset is sampled high (name kept for legacy users).
module register4_async_reset #(
    parameter int unsigned            WIDTH       = 4,
    parameter logic [WIDTH-1:0]       RESET_VALUE = {WIDTH{1'b0}}
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] data,
    output logic [WIDTH-1:0] q
);

    // Stage 1: single flop stage, reset takes priority over capture
    always_ff @(posedge clk) begin
        if (reset) begin
            q <= RESET_VALUE;
        end else begin
            q <= data;
        end
    end

endmodule

// File: tb/tb_register4_async_reset.sv
// Bench for register4_async_reset: directed steps from the test plan, then randomized
// traffic on a default 4-bit instance and an 8-bit instance with RESET_VALUE = 8'hA5.
module tb_register4_async_reset;

    logic       clk;
    logic       reset4;
    logic [3:0] data4;
    logic [3:0] q4;
    logic       reset8;
    logic [7:0] data8;
    logic [7:0] q8;

    int checks;
    int errors;

    // Reference expectations for the two instances
    logic [3:0] exp4;
    logic [7:0] exp8;

    register4_async_reset dut4 (
        .clk   (clk),
        .reset (reset4),
        .data  (data4),
        .q     (q4)
    );

    register4_async_reset #(
        .WIDTH       (8),
        .RESET_VALUE (8'hA5)
    ) dut8 (
        .clk   (clk),
        .reset (reset8),
        .data  (data8),
        .q     (q8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, observed, expected);
        end
    endtask

    // Model of one rising edge: reset wins, otherwise the word is captured
    function automatic logic [7:0] next_q(input logic rst, input logic [7:0] d, input logic [7:0] rv);
        return rst ? rv : d;
    endfunction

    initial begin
        checks = 0;
        errors = 0;
        reset4 = 1'b1;
        data4  = 4'b1010;
        reset8 = 1'b1;
        data8  = 8'h3C;

        // Two reset edges with data = 1010
        @(posedge clk); #1;
        check("reset_edge1_q4", {4'b0, q4}, 8'h00);
        check("reset_edge1_q8", q8, 8'hA5);
        @(posedge clk); #1;
        check("reset_edge2_q4", {4'b0, q4}, 8'h00);

        // Deassert reset while clk low; no change until the edge
        @(negedge clk);
        reset4 = 1'b0;
        #1;
        check("deassert_before_edge", {4'b0, q4}, 8'h00);
        @(posedge clk); #1;
        check("deassert_load", {4'b0, q4}, 8'h0A);

        // Reassert reset while clk low: synchronous clear only at the edge
        @(negedge clk);
        reset4 = 1'b1;
        #1;
        check("reassert_before_edge", {4'b0, q4}, 8'h0A);
        @(posedge clk); #1;
        check("reassert_after_edge", {4'b0, q4}, 8'h00);

        // Reload 1010, then change to 0101 while clk low
        @(negedge clk);
        reset4 = 1'b0;
        @(posedge clk); #1;
        check("reload_1010", {4'b0, q4}, 8'h0A);
        @(negedge clk);
        data4 = 4'b0101;
        #1;
        check("data_change_hold", {4'b0, q4}, 8'h0A);
        @(posedge clk); #1;
        check("data_change_load", {4'b0, q4}, 8'h05);

        // Toggle data between edges; only the value at the edge matters
        data4 = 4'b1111;
        #2 data4 = 4'b0000;
        #1 check("toggle_hold_mid", {4'b0, q4}, 8'h05);
        @(negedge clk);
        data4 = 4'b0110;
        #2 data4 = 4'b1001;
        #1 check("toggle_hold_low", {4'b0, q4}, 8'h05);
        @(posedge clk); #1;
        check("toggle_edge_value", {4'b0, q4}, 8'h09);

        // Reset priority over data on the same edge
        @(negedge clk);
        reset4 = 1'b1;
        data4  = 4'b1111;
        @(posedge clk); #1;
        check("reset_priority", {4'b0, q4}, 8'h00);

        // Wide instance: load after its reset value
        @(negedge clk);
        reset8 = 1'b0;
        data8  = 8'h3C;
        #1;
        check("w8_hold_reset_value", q8, 8'hA5);
        @(posedge clk); #1;
        check("w8_load_3c", q8, 8'h3C);

        // Randomized traffic against the model
        exp4 = q4;
        exp8 = q8;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            reset4 = ($urandom_range(0, 7) == 0);
            reset8 = ($urandom_range(0, 7) == 0);
            data4  = 4'($urandom);
            data8  = 8'($urandom);
            #1;
            check("rand_hold_q4", {4'b0, q4}, {4'b0, exp4});
            check("rand_hold_q8", q8, exp8);
            exp4 = 4'(next_q(reset4, {4'b0, data4}, 8'h00));
            exp8 = next_q(reset8, data8, 8'hA5);
            @(posedge clk); #1;
            check("rand_edge_q4", {4'b0, q4}, {4'b0, exp4});
            check("rand_edge_q8", q8, exp8);
            // Disturb inputs mid-high-phase; outputs must not follow
            data4  = 4'($urandom);
            data8  = 8'($urandom);
            reset4 = ~reset4;
            reset8 = ~reset8;
            #2;
            check("rand_midhigh_q4", {4'b0, q4}, {4'b0, exp4});
            check("rand_midhigh_q8", q8, exp8);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/register4_async_reset.md
Name: register4_async_reset

Overview:
- Parameterizable data register, 4 bits wide by default, clocked on the rising edge of `clk`.
- Each rising edge captures the `data` input onto `q`, unless `reset` is asserted.
- Used as a basic storage/pipeline element wherever a resettable word register is needed.
- The module name is kept for compatibility with existing instantiations. The reset is synchronous despite the name.

Parameters:
- WIDTH, 4: bit width of `data` and `q`. Legal range is 1 or more.
- RESET_VALUE, {WIDTH{1'b0}}: value loaded into `q` when reset is applied. Default is all zeros.

Ports:
- clk  input  1  system clock. All state changes occur on its rising edge.
- reset  input  1  reset. Synchronous and active-high. Sampled only on the rising edge of `clk`.
- data  input  WIDTH  word to be registered.
- q  output  WIDTH  registered output, driven directly from flops. No combinational path from any input.

Behaviour:
- Single clock domain, `clk`. One clock and synchronous, active-high reset are fixed requirements.
- At each rising edge of `clk`:
  - `reset` = 1 → `q` <= RESET_VALUE (0000 by default).
  - `reset` = 0 → `q` <= `data`.
- Reset has priority over data capture when both apply on the same edge.
- Latency: one clock. `q` reflects the `data` sampled at the most recent non-reset rising edge.
- Between rising edges, `q` holds its value regardless of changes on `data` or `reset`.
- Reset mid-operation:
  - Asserting `reset` while `clk` is high or low does NOT change `q` immediately.
  - `q` clears only at the next rising edge with `reset` = 1.
  - Deasserting `reset` takes effect at the next rising edge, which loads `data`.
- Power-up: no initial value is required. `q` is unknown until the first rising edge with `reset` = 1 or with valid `data`.
- No enable. The register loads on every non-reset edge.
- No gating or derived clocks, and no latches.
- `data` is sampled with ordinary setup/hold to `clk`. `data` changing coincident with the falling edge has no effect.
- Width rules: `data` and `q` are exactly WIDTH bits. RESET_VALUE is truncated or zero-extended to WIDTH.

Test Plan:
- Hold `reset` = 1, `data` = 4'b1010, for two rising edges → `q` = 4'b0000 after the first edge and stays 0000.
- Deassert `reset` while `clk` is low with `data` = 4'b1010, then apply a rising edge → `q` = 4'b1010 one edge later.
- Reassert `reset` while `clk` is low, with `data` still 1010:
  - before the next rising edge → `q` remains 1010 (proves the reset is synchronous).
  - after the next rising edge → `q` = 0000.
- With `reset` = 0:
  - change `data` 1010 → 0101 while `clk` is low → `q` unchanged until the rising edge, then 0101.
  - toggle `data` between edges → `q` shows only the value present at each rising edge.
- Same edge with `reset` = 1 and `data` = 4'b1111 → `q` = 0000 (reset priority).
- Instantiate with WIDTH = 8 and RESET_VALUE = 8'hA5: reset edge → `q` = 8'hA5, then load 8'h3C → `q` = 8'h3C.
